// File: rtl/dc_router_pkg.sv
// Shared definitions for the DC router and its accelerator-side FIFOs.
// Holds the data-path word width, the FIFO geometry used by every
// accelerator buffer, and the instruction encodings the router decodes.
package dc_router_pkg;

  localparam int DC_DATA_W     = 128;
  localparam int DC_FIFO_DEPTH = 16;
  localparam int DC_FIFO_AW    = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_FFT  = 2'b01,
    OP_FIR  = 2'b10,
    OP_IIR  = 2'b11
  } dc_op_e;

endpackage

// File: rtl/dc_fifo_mem.sv
// DEPTH x WIDTH register array with one write port and one registered
// read port.
//   clk_i      system clock, rising edge
//   reset_i    asynchronous active-high reset (clears the read register only)
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe; rd_data_o updates on the following edge
//   rd_addr_i  read address
//   rd_data_o  registered read data, held when no read is strobed
module dc_fifo_mem
  import dc_router_pkg::*;
#(
  parameter int WIDTH  = DC_DATA_W,
  parameter int DEPTH  = DC_FIFO_DEPTH,
  parameter int ADDR_W = DC_FIFO_AW
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage has no reset: contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register is cleared on reset so no stale word is ever presented.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dc_acc_fifo.sv
// Responder end of the router's put/get FIFO handshake; one instance per
// direction per accelerator.
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   flush      synchronous clear between instructions (highest priority)
//   put_req    write request;  put_data sampled when accepted
//   get_req    read request;   get_data/get_valid appear one edge later
//   full/empty registered occupancy flags, level = occupancy 0..DEPTH
//   overflow   sticky: put attempted while full
//   underflow  sticky: get attempted while empty
module dc_acc_fifo
  import dc_router_pkg::*;
#(
  parameter int WIDTH  = DC_DATA_W,
  parameter int DEPTH  = DC_FIFO_DEPTH,
  parameter int ADDR_W = DC_FIFO_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              put_req,
  input  logic [WIDTH-1:0]  put_data,
  input  logic              get_req,
  output logic [WIDTH-1:0]  get_data,
  output logic              get_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              valid_q, valid_d;
  logic              put_ok, get_ok;

  // Acceptance uses the registered flags, so a put into an empty FIFO can
  // never be read back in the same cycle.
  assign put_ok = put_req & ~full_q;
  assign get_ok = get_req & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    valid_d  = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (put_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (get_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        valid_d  = 1'b1;
      end
      unique case ({put_ok, get_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // The error flags record the attempt, even when the opposite
      // request in the same cycle is accepted.
      if (put_req && full_q) begin
        ovf_d = 1'b1;
      end
      if (get_req && empty_q) begin
        unf_d = 1'b1;
      end
    end
    full_d  = (level_d == LEVEL_FULL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
    end
  end

  dc_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (put_ok & ~flush),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (put_data),
    .rd_en_i   (get_ok & ~flush),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (get_data)
  );

  assign get_valid = valid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_dc_acc_fifo.sv
// Bench for dc_acc_fifo: a queue-based model of the FIFO is advanced on
// every clock edge and compared against the DUT on each falling edge,
// with a few literal expectations along the directed sequences.
module tb_dc_acc_fifo;

  localparam int W = 128;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         put_req;
  logic [W-1:0] put_data;
  logic         get_req;
  logic [W-1:0] get_data;
  logic         get_valid;
  logic         full;
  logic         empty;
  logic [4:0]   level;
  logic         overflow;
  logic         underflow;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  logic [W-1:0] modelQ [$];
  logic [W-1:0] expData;
  logic         expValid;
  logic         expOvf;
  logic         expUnf;

  dc_acc_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .put_req   (put_req),
    .put_data  (put_data),
    .get_req   (get_req),
    .get_data  (get_data),
    .get_valid (get_valid),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    modelQ.delete();
    expData  = '0;
    expValid = 1'b0;
    expOvf   = 1'b0;
    expUnf   = 1'b0;
  endfunction

  // FIFO behaviour in terms of a queue: flags come from the queue size
  // before the edge, a get takes the oldest entry, a put appends.
  function automatic void modelStep(input bit p, input bit g, input bit f, input logic [W-1:0] d);
    bit wasFull, wasEmpty;
    if (f) begin
      modelQ.delete();
      expValid = 1'b0;
      expOvf   = 1'b0;
      expUnf   = 1'b0;
      return;
    end
    wasFull  = (modelQ.size() == D);
    wasEmpty = (modelQ.size() == 0);
    expValid = 1'b0;
    if (p && wasFull)  expOvf = 1'b1;
    if (g && wasEmpty) expUnf = 1'b1;
    if (g && !wasEmpty) begin
      expData  = modelQ.pop_front();
      expValid = 1'b1;
    end
    if (p && !wasFull) modelQ.push_back(d);
  endfunction

  // Called shortly after a rising edge: drives one cycle of inputs and
  // advances the model on the edge that consumes them.
  task automatic applyStimulus(input bit p, input bit g, input bit f, input logic [W-1:0] d);
    put_req  = p;
    get_req  = g;
    flush    = f;
    put_data = d;
    @(posedge clk);
    modelStep(p, g, f, d);
    #1;
  endtask

  always @(negedge clk) begin
    if (checkEn && !reset) begin
      checkOutput("level",     W'(level),     W'(modelQ.size()));
      checkOutput("full",      W'(full),      W'(modelQ.size() == D));
      checkOutput("empty",     W'(empty),     W'(modelQ.size() == 0));
      checkOutput("get_valid", W'(get_valid), W'(expValid));
      checkOutput("get_data",  get_data,      expData);
      checkOutput("overflow",  W'(overflow),  W'(expOvf));
      checkOutput("underflow", W'(underflow), W'(expUnf));
    end
  end

  function automatic logic [W-1:0] randWord();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int bias;
    reset    = 1'b1;
    flush    = 1'b0;
    put_req  = 1'b0;
    get_req  = 1'b0;
    put_data = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    checkEn = 1'b1;

    // 1. idle after reset
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 0, '0);
    checkOutput("rst_empty", W'(empty), W'(1));
    checkOutput("rst_data",  get_data,  W'(0));

    // 2. fill with 1..16, then drain in order
    for (int i = 1; i <= D; i++) applyStimulus(1, 0, 0, W'(i));
    checkOutput("fill_level", W'(level), W'(16));
    checkOutput("fill_full",  W'(full),  W'(1));
    applyStimulus(0, 1, 0, '0);
    checkOutput("first_get_data",  get_data,       W'(1));
    checkOutput("first_get_valid", W'(get_valid), W'(1));
    for (int i = 2; i <= D; i++) applyStimulus(0, 1, 0, '0);
    checkOutput("last_get_data", get_data, W'(16));
    applyStimulus(0, 0, 0, '0);
    checkOutput("drain_empty", W'(empty), W'(1));

    // 3. overflow on a full FIFO, underflow on an empty one
    for (int i = 0; i < D; i++) applyStimulus(1, 0, 0, randWord());
    applyStimulus(1, 0, 0, W'(32'hDEAD));
    checkOutput("ovf_flag",  W'(overflow), W'(1));
    checkOutput("ovf_level", W'(level),    W'(16));
    for (int i = 0; i < D; i++) applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 0, 0, '0);
    checkOutput("unf_flag",  W'(underflow), W'(1));
    checkOutput("unf_valid", W'(get_valid), W'(0));

    // 4. steady put+get at level 8, then put+get at full and at empty
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, randWord());
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0, randWord());
    checkOutput("steady_level", W'(level), W'(8));
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, randWord());
    applyStimulus(1, 1, 0, randWord());
    checkOutput("full_pg_level", W'(level), W'(15));
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, '0);
    applyStimulus(1, 1, 0, W'(32'h1234));
    checkOutput("empty_pg_level", W'(level), W'(1));
    applyStimulus(0, 1, 0, '0);
    checkOutput("empty_pg_data", get_data, W'(32'h1234));

    // 5. flush with a concurrent put, then a clean round trip
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, randWord());
    applyStimulus(1, 0, 1, W'(32'h77));
    checkOutput("flush_level", W'(level),     W'(0));
    checkOutput("flush_ovf",   W'(overflow),  W'(0));
    checkOutput("flush_unf",   W'(underflow), W'(0));
    applyStimulus(1, 0, 0, W'(8'hA5));
    applyStimulus(0, 1, 0, '0);
    checkOutput("a5_data", get_data, W'(8'hA5));

    // 6. asynchronous reset between edges
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, randWord());
    applyStimulus(0, 1, 0, '0);
    put_req = 1'b0;
    get_req = 1'b0;
    #2;
    checkEn = 1'b0;
    reset   = 1'b1;
    #1;
    checkOutput("async_empty", W'(empty),     W'(1));
    checkOutput("async_level", W'(level),     W'(0));
    checkOutput("async_valid", W'(get_valid), W'(0));
    checkOutput("async_data",  get_data,      W'(0));
    modelReset();
    @(posedge clk);
    #3;
    reset   = 1'b0;
    checkEn = 1'b1;
    applyStimulus(0, 1, 0, '0);
    checkOutput("post_rst_unf", W'(underflow), W'(1));

    // Randomised traffic with drifting fill bias and occasional flushes
    bias = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) bias = $urandom_range(15, 85);
      applyStimulus($urandom_range(0, 99) < bias,
                    $urandom_range(0, 99) >= bias - 10,
                    $urandom_range(0, 99) < 2,
                    randWord());
    end

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
